itlb_miss_ctrl: RTL and testbench

//  Sits between instruction fetch / ITLB read ports and the page-table walker (PTW). Captures ITLB misses

---
 rtl/itlb_pkg.sv | 28 ++
 rtl/itlb_missq.sv | 97 +++++++++
 rtl/itlb_miss_ctrl.sv | 160 ++++++++++++++++
 tb/tb_itlb_miss_ctrl.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/itlb_pkg.sv
// Shared types for the ITLB miss path: miss-handler states, queued miss keys and ITLB fill records.
package itlb_pkg;
  localparam int NPHYS  = 44;
  localparam int VA_SZ  = 48;
  localparam int MISSQ  = 2;
  localparam int VPN_W  = VA_SZ - 12;
  localparam int PPN_W  = NPHYS - 12;
  localparam int ASID_W = 16;
  localparam int QCNT_W = $clog2(MISSQ) + 1;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, FILL} miss_state_t;

  typedef struct packed {
    logic [VPN_W-1:0]  vaddr;
    logic [ASID_W-1:0] asid;
  } itlb_miss_t;

  typedef struct packed {
    logic [VPN_W-1:0]  vaddr;
    logic [ASID_W-1:0] asid;
    logic [PPN_W-1:0]  paddr;
    logic [3:0]        gaux;
    logic              sz_2mb;
    logic              sz_4mb;
    logic              sz_1gb;
    logic              sz_512gb;
  } itlb_fill_t;
endpackage

// File: rtl/itlb_missq.sv
// Circular FIFO of pending ITLB misses with two parallel probe comparators and a single-cycle flush.
module itlb_missq
  import itlb_pkg::*;
#(
  parameter int DEPTH = MISSQ
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push0,
  input  itlb_miss_t               push0_data,
  input  logic                     push1,
  input  itlb_miss_t               push1_data,
  input  logic                     pop,
  output itlb_miss_t               head,
  input  itlb_miss_t               probe_a,
  input  itlb_miss_t               probe_b,
  output logic                     hit_a,
  output logic                     hit_b,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  itlb_miss_t     mem_q [DEPTH];
  itlb_miss_t     mem_d [DEPTH];
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [PW-1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d, wr_nxt;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           do_pop;

  assign wr_nxt = wr_ptr_q + PW'(1);
  assign do_pop = pop && !empty;

  // With only port 1 pushing, it takes the first free slot.
  always_comb begin
    mem_d    = mem_q;
    valid_d  = valid_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    if (flush) begin
      valid_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (do_pop) begin
        valid_d[rd_ptr_q] = 1'b0;
        rd_ptr_d          = rd_ptr_q + PW'(1);
      end
      if (push0 || push1) begin
        mem_d[wr_ptr_q]   = push0 ? push0_data : push1_data;
        valid_d[wr_ptr_q] = 1'b1;
        wr_ptr_d          = wr_nxt;
      end
      if (push0 && push1) begin
        mem_d[wr_nxt]   = push1_data;
        valid_d[wr_nxt] = 1'b1;
        wr_ptr_d        = wr_nxt + PW'(1);
      end
      cnt_d = cnt_q + CW'(push0) + CW'(push1) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      valid_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      valid_q  <= valid_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    hit_a = 1'b0;
    hit_b = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && mem_q[i] == probe_a) hit_a = 1'b1;
      if (valid_q[i] && mem_q[i] == probe_b) hit_b = 1'b1;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = cnt_q;
  assign full  = (cnt_q == CW'(DEPTH));
  assign empty = (cnt_q == '0);
endmodule

// File: rtl/itlb_miss_ctrl.sv
// ITLB miss controller: dedups fetch misses, queues them, runs one page walk at a time and fills the ITLB.
module itlb_miss_ctrl
  import itlb_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              miss_0,
  input  logic [VPN_W-1:0]  miss_vaddr_0,
  input  logic [ASID_W-1:0] miss_asid_0,
  input  logic              miss_1,
  input  logic [VPN_W-1:0]  miss_vaddr_1,
  input  logic [ASID_W-1:0] miss_asid_1,
  input  logic              inval,
  output logic              ptw_req,
  output logic [VPN_W-1:0]  ptw_req_vaddr,
  output logic [ASID_W-1:0] ptw_req_asid,
  input  logic              ptw_ack,
  input  logic              ptw_done,
  input  logic              ptw_fault,
  input  logic [PPN_W-1:0]  ptw_paddr,
  input  logic [3:0]        ptw_gaux,
  input  logic              ptw_2mB,
  input  logic              ptw_4mB,
  input  logic              ptw_1gB,
  input  logic              ptw_512gB,
  output logic              wr_entry,
  output logic [VPN_W-1:0]  wr_vaddr,
  output logic [ASID_W-1:0] wr_asid,
  output logic [PPN_W-1:0]  wr_paddr,
  output logic [3:0]        wr_gaux,
  output logic              wr_2mB,
  output logic              wr_4mB,
  output logic              wr_1gB,
  output logic              wr_512gB,
  output logic              fault_valid,
  output logic [VPN_W-1:0]  fault_vaddr,
  output logic              miss_busy,
  output logic              miss_full,
  output miss_state_t       dbg_state
);
  miss_state_t       state_q, state_d;
  itlb_miss_t        act_q, act_d, key0, key1, q_head;
  itlb_fill_t        fill_q, fill_d;
  logic              fault_q, fault_d, discard_q, discard_d;
  logic              hit0, hit1, q_full, q_empty, pop, push0, push1;
  logic              act_valid, dup0, dup1, room1;
  logic [QCNT_W-1:0] q_cnt;

  assign key0      = {miss_vaddr_0, miss_asid_0};
  assign key1      = {miss_vaddr_1, miss_asid_1};
  assign act_valid = (state_q != IDLE);
  assign dup0      = hit0 || (act_valid && key0 == act_q);
  assign dup1      = hit1 || (act_valid && key1 == act_q) || (miss_0 && key1 == key0);
  assign room1     = push0 ? (q_cnt < QCNT_W'(MISSQ - 1)) : !q_full;
  assign push0     = miss_0 && !dup0 && !q_full && !inval;
  assign push1     = miss_1 && !dup1 && room1 && !inval;

  itlb_missq #(.DEPTH(MISSQ)) u_missq (
    .clk        (clk),
    .reset      (reset),
    .flush      (inval),
    .push0      (push0),
    .push0_data (key0),
    .push1      (push1),
    .push1_data (key1),
    .pop        (pop),
    .head       (q_head),
    .probe_a    (key0),
    .probe_b    (key1),
    .hit_a      (hit0),
    .hit_b      (hit1),
    .count      (q_cnt),
    .full       (q_full),
    .empty      (q_empty)
  );

  // ptw_req/ptw_ack: ptw_req is held with stable vaddr/asid until the cycle ptw_ack is seen high;
  // the walk is accepted in that cycle. ptw_req is never retracted, even after an invalidate.
  always_comb begin
    state_d     = state_q;
    act_d       = act_q;
    fill_d      = fill_q;
    fault_d     = fault_q;
    discard_d   = discard_q;
    pop         = 1'b0;
    ptw_req     = 1'b0;
    wr_entry    = 1'b0;
    fault_valid = 1'b0;
    case (state_q)
      IDLE: begin
        if (!q_empty && !inval) begin
          pop     = 1'b1;
          act_d   = q_head;
          state_d = REQ;
        end
      end
      REQ: begin
        ptw_req = 1'b1;
        if (inval) discard_d = 1'b1;
        if (ptw_ack) state_d = WAIT;
      end
      WAIT: begin
        if (inval) discard_d = 1'b1;
        if (ptw_done) begin
          state_d         = FILL;
          fault_d         = ptw_fault;
          fill_d.vaddr    = act_q.vaddr;
          fill_d.asid     = act_q.asid;
          fill_d.paddr    = ptw_paddr;
          fill_d.gaux     = ptw_gaux;
          fill_d.sz_2mb   = ptw_2mB;
          fill_d.sz_4mb   = ptw_4mB;
          fill_d.sz_1gb   = ptw_1gB;
          fill_d.sz_512gb = ptw_512gB;
        end
      end
      FILL: begin
        // An invalidate landing on the fill cycle itself also kills the write.
        if (!(discard_q || inval)) begin
          wr_entry    = !fault_q;
          fault_valid = fault_q;
        end
        discard_d = 1'b0;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      act_q     <= '0;
      fill_q    <= '0;
      fault_q   <= 1'b0;
      discard_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      act_q     <= act_d;
      fill_q    <= fill_d;
      fault_q   <= fault_d;
      discard_q <= discard_d;
    end
  end

  assign ptw_req_vaddr = act_q.vaddr;
  assign ptw_req_asid  = act_q.asid;
  assign fault_vaddr   = act_q.vaddr;
  assign wr_vaddr      = fill_q.vaddr;
  assign wr_asid       = fill_q.asid;
  assign wr_paddr      = fill_q.paddr;
  assign wr_gaux       = fill_q.gaux;
  assign wr_2mB        = fill_q.sz_2mb;
  assign wr_4mB        = fill_q.sz_4mb;
  assign wr_1gB        = fill_q.sz_1gb;
  assign wr_512gB      = fill_q.sz_512gb;
  assign miss_busy     = !q_empty || act_valid;
  assign miss_full     = q_full;
  assign dbg_state     = state_q;
endmodule

// File: tb/tb_itlb_miss_ctrl.sv
// Directed bench for itlb_miss_ctrl: cycle-by-cycle vector table plus hand sequences for full queue and reset.
module tb_itlb_miss_ctrl;
  import itlb_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        miss_0, miss_1, inval, ptw_ack, ptw_done, ptw_fault;
  logic [35:0] miss_vaddr_0, miss_vaddr_1;
  logic [15:0] miss_asid_0, miss_asid_1;
  logic [31:0] ptw_paddr;
  logic [3:0]  ptw_gaux;
  logic        ptw_2mB, ptw_4mB, ptw_1gB, ptw_512gB;
  logic        ptw_req, wr_entry, fault_valid, miss_busy, miss_full;
  logic [35:0] ptw_req_vaddr, wr_vaddr, fault_vaddr;
  logic [15:0] ptw_req_asid, wr_asid;
  logic [31:0] wr_paddr;
  logic [3:0]  wr_gaux;
  logic        wr_2mB, wr_4mB, wr_1gB, wr_512gB;
  miss_state_t dbg_state;

  itlb_miss_ctrl dut (
    .clk(clk), .reset(reset),
    .miss_0(miss_0), .miss_vaddr_0(miss_vaddr_0), .miss_asid_0(miss_asid_0),
    .miss_1(miss_1), .miss_vaddr_1(miss_vaddr_1), .miss_asid_1(miss_asid_1),
    .inval(inval),
    .ptw_req(ptw_req), .ptw_req_vaddr(ptw_req_vaddr), .ptw_req_asid(ptw_req_asid),
    .ptw_ack(ptw_ack), .ptw_done(ptw_done), .ptw_fault(ptw_fault), .ptw_paddr(ptw_paddr),
    .ptw_gaux(ptw_gaux), .ptw_2mB(ptw_2mB), .ptw_4mB(ptw_4mB), .ptw_1gB(ptw_1gB), .ptw_512gB(ptw_512gB),
    .wr_entry(wr_entry), .wr_vaddr(wr_vaddr), .wr_asid(wr_asid), .wr_paddr(wr_paddr),
    .wr_gaux(wr_gaux), .wr_2mB(wr_2mB), .wr_4mB(wr_4mB), .wr_1gB(wr_1gB), .wr_512gB(wr_512gB),
    .fault_valid(fault_valid), .fault_vaddr(fault_vaddr),
    .miss_busy(miss_busy), .miss_full(miss_full), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        m0;
    logic [35:0] va0;
    logic [15:0] as0;
    logic        m1;
    logic [35:0] va1;
    logic [15:0] as1;
    logic        inv;
    logic        ack;
    logic        done;
    logic        flt;
    logic [31:0] pa;
    logic [4:0]  flags;  // {ptw_req, wr_entry, fault_valid, miss_busy, miss_full}
    logic [35:0] eva;
    logic [15:0] eas;
    logic [31:0] epa;
  } vec_t;

  vec_t        tbl [64];
  int          n_vec = 0;
  int          total = 0;
  int          bad = 0;
  int          walks = 0;
  logic [35:0] exp_q [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic m0, input logic [35:0] va0, input logic [15:0] as0,
                     input logic m1, input logic [35:0] va1, input logic [15:0] as1,
                     input logic inv, input logic ack, input logic done, input logic flt,
                     input logic [31:0] pa, input logic [4:0] flags,
                     input logic [35:0] eva, input logic [15:0] eas, input logic [31:0] epa);
    tbl[n_vec] = '{m0, va0, as0, m1, va1, as1, inv, ack, done, flt, pa, flags, eva, eas, epa};
    n_vec++;
  endtask

  task automatic drive_zero();
    miss_0 = 0; miss_vaddr_0 = '0; miss_asid_0 = '0;
    miss_1 = 0; miss_vaddr_1 = '0; miss_asid_1 = '0;
    inval = 0; ptw_ack = 0; ptw_done = 0; ptw_fault = 0; ptw_paddr = '0;
    ptw_gaux = '0; ptw_2mB = 0; ptw_4mB = 0; ptw_1gB = 0; ptw_512gB = 0;
  endtask

  function automatic logic [31:0] pa_of(input logic [35:0] va);
    return va[31:0] ^ 32'h000A5A5A;
  endfunction

  // Simple PTW model: acks every request at once and completes the walk the following cycle.
  task automatic serve(input int cycles);
    logic        pend;
    logic [35:0] pva;
    logic [35:0] e;
    pend = 1'b0;
    pva  = '0;
    for (int c = 0; c < cycles; c++) begin
      @(posedge clk); #1;
      drive_zero();
      ptw_done  = pend;
      ptw_paddr = pend ? pa_of(pva) : 32'h0;
      ptw_gaux  = pend ? pva[3:0] : 4'h0;
      ptw_2mB   = pend && pva[0];
      ptw_4mB   = pend && pva[2];
      ptw_1gB   = pend && pva[1];
      ptw_512gB = pend && pva[3];
      pend      = 1'b0;
      ptw_ack   = ptw_req;
      if (ptw_req) begin
        pend = 1'b1;
        pva  = ptw_req_vaddr;
      end
      #1;
      if (wr_entry) begin
        walks++;
        if (exp_q.size() == 0) begin
          check("wr_extra", 64'(1), 64'(0));
        end else begin
          e = exp_q.pop_front();
          check("serve_wr_va", 64'(wr_vaddr), 64'(e));
          check("serve_wr_pa", 64'(wr_paddr), 64'(pa_of(e)));
          check("serve_wr_aux", 64'({wr_gaux, wr_2mB, wr_4mB, wr_1gB, wr_512gB}),
                64'({e[3:0], e[0], e[2], e[1], e[3]}));
        end
      end
    end
    drive_zero();
  endtask

  initial begin
    drive_zero();

    // single miss, request held until ack
    add(1, 'h12345, 5, 0, 0, 0, 0, 0, 0, 0, 0,        5'b00000, 0, 0, 0);
    add(0, 0, 0,       0, 0, 0, 0, 0, 0, 0, 0,        5'b00010, 0, 0, 0);
    add(0, 0, 0,       0, 0, 0, 0, 0, 0, 0, 0,        5'b10010, 'h12345, 5, 0);
    add(0, 0, 0,       0, 0, 0, 0, 1, 0, 0, 0,        5'b10010, 'h12345, 5, 0);
    add(0, 0, 0,       0, 0, 0, 0, 0, 0, 0, 0,        5'b00010, 0, 0, 0);
    add(0, 0, 0,       0, 0, 0, 0, 0, 1, 0, 'hABCDE,  5'b00010, 0, 0, 0);
    add(0, 0, 0,       0, 0, 0, 0, 0, 0, 0, 0,        5'b01010, 'h12345, 5, 'hABCDE);
    add(0, 0, 0,       0, 0, 0, 0, 0, 0, 0, 0,        5'b00000, 0, 0, 0);
    // same miss on both ports: one walk
    add(1, 'h400, 1, 1, 'h400, 1, 0, 0, 0, 0, 0,      5'b00000, 0, 0, 0);
    add(0, 0, 0,     0, 0, 0,     0, 0, 0, 0, 0,      5'b00010, 0, 0, 0);
    add(0, 0, 0,     0, 0, 0,     0, 1, 0, 0, 0,      5'b10010, 'h400, 1, 0);
    add(0, 0, 0,     0, 0, 0,     0, 0, 1, 0, 'h11111, 5'b00010, 0, 0, 0);
    add(0, 0, 0,     0, 0, 0,     0, 0, 0, 0, 0,      5'b01010, 'h400, 1, 'h11111);
    add(0, 0, 0,     0, 0, 0,     0, 0, 0, 0, 0,      5'b00000, 0, 0, 0);
    // distinct misses on both ports: two walks in port order
    add(1, 'h500, 2, 1, 'h600, 2, 0, 0, 0, 0, 0,      5'b00000, 0, 0, 0);
    add(0, 0, 0,     0, 0, 0,     0, 0, 0, 0, 0,      5'b00011, 0, 0, 0);
    add(0, 0, 0,     0, 0, 0,     0, 1, 0, 0, 0,      5'b10010, 'h500, 2, 0);
    add(0, 0, 0,     0, 0, 0,     0, 0, 1, 0, 'h22222, 5'b00010, 0, 0, 0);
    add(0, 0, 0,     0, 0, 0,     0, 0, 0, 0, 0,      5'b01010, 'h500, 2, 'h22222);
    add(0, 0, 0,     0, 0, 0,     0, 0, 0, 0, 0,      5'b00010, 0, 0, 0);
    add(0, 0, 0,     0, 0, 0,     0, 1, 0, 0, 0,      5'b10010, 'h600, 2, 0);
    add(0, 0, 0,     0, 0, 0,     0, 0, 1, 0, 'h33333, 5'b00010, 0, 0, 0);
    add(0, 0, 0,     0, 0, 0,     0, 0, 0, 0, 0,      5'b01010, 'h600, 2, 'h33333);
    add(0, 0, 0,     0, 0, 0,     0, 0, 0, 0, 0,      5'b00000, 0, 0, 0);
    // fault; re-miss of the active walk is dropped
    add(1, 'h777, 3, 0, 0, 0, 0, 0, 0, 0, 0,          5'b00000, 0, 0, 0);
    add(0, 0, 0,     0, 0, 0, 0, 0, 0, 0, 0,          5'b00010, 0, 0, 0);
    add(0, 0, 0,     0, 0, 0, 0, 1, 0, 0, 0,          5'b10010, 'h777, 3, 0);
    add(1, 'h777, 3, 0, 0, 0, 0, 0, 1, 1, 0,          5'b00010, 0, 0, 0);
    add(0, 0, 0,     0, 0, 0, 0, 0, 0, 0, 0,          5'b00110, 'h777, 0, 0);
    add(0, 0, 0,     0, 0, 0, 0, 0, 0, 0, 0,          5'b00000, 0, 0, 0);
    // invalidate in WAIT flushes queue and kills the fill
    add(1, 'h900, 4, 1, 'h901, 4, 0, 0, 0, 0, 0,      5'b00000, 0, 0, 0);
    add(0, 0, 0,     0, 0, 0,     0, 0, 0, 0, 0,      5'b00011, 0, 0, 0);
    add(0, 0, 0,     0, 0, 0,     0, 1, 0, 0, 0,      5'b10010, 'h900, 4, 0);
    add(0, 0, 0,     0, 0, 0,     1, 0, 0, 0, 0,      5'b00010, 0, 0, 0);
    add(0, 0, 0,     0, 0, 0,     0, 0, 1, 0, 'h44444, 5'b00010, 0, 0, 0);
    add(0, 0, 0,     0, 0, 0,     0, 0, 0, 0, 0,      5'b00010, 0, 0, 0);
    add(0, 0, 0,     0, 0, 0,     0, 0, 0, 0, 0,      5'b00000, 0, 0, 0);
    // next walk fills normally again
    add(1, 'hA00, 4, 0, 0, 0, 0, 0, 0, 0, 0,          5'b00000, 0, 0, 0);
    add(0, 0, 0,     0, 0, 0, 0, 0, 0, 0, 0,          5'b00010, 0, 0, 0);
    add(0, 0, 0,     0, 0, 0, 0, 1, 0, 0, 0,          5'b10010, 'hA00, 4, 0);
    add(0, 0, 0,     0, 0, 0, 0, 0, 1, 0, 'h55555,    5'b00010, 0, 0, 0);
    add(0, 0, 0,     0, 0, 0, 0, 0, 0, 0, 0,          5'b01010, 'hA00, 4, 'h55555);
    add(0, 0, 0,     0, 0, 0, 0, 0, 0, 0, 0,          5'b00000, 0, 0, 0);
    // invalidate coincident with done
    add(1, 'hB00, 6, 0, 0, 0, 0, 0, 0, 0, 0,          5'b00000, 0, 0, 0);
    add(0, 0, 0,     0, 0, 0, 0, 0, 0, 0, 0,          5'b00010, 0, 0, 0);
    add(0, 0, 0,     0, 0, 0, 0, 1, 0, 0, 0,          5'b10010, 'hB00, 6, 0);
    add(0, 0, 0,     0, 0, 0, 1, 0, 1, 0, 'h66666,    5'b00010, 0, 0, 0);
    add(0, 0, 0,     0, 0, 0, 0, 0, 0, 0, 0,          5'b00010, 0, 0, 0);
    add(0, 0, 0,     0, 0, 0, 0, 0, 0, 0, 0,          5'b00000, 0, 0, 0);
    // invalidate in REQ: request stays up until ack, fill discarded
    add(1, 'hC00, 7, 0, 0, 0, 0, 0, 0, 0, 0,          5'b00000, 0, 0, 0);
    add(0, 0, 0,     0, 0, 0, 0, 0, 0, 0, 0,          5'b00010, 0, 0, 0);
    add(0, 0, 0,     0, 0, 0, 1, 0, 0, 0, 0,          5'b10010, 'hC00, 7, 0);
    add(0, 0, 0,     0, 0, 0, 0, 1, 0, 0, 0,          5'b10010, 'hC00, 7, 0);
    add(0, 0, 0,     0, 0, 0, 0, 0, 1, 0, 'h77777,    5'b00010, 0, 0, 0);
    add(0, 0, 0,     0, 0, 0, 0, 0, 0, 0, 0,          5'b00010, 0, 0, 0);
    add(0, 0, 0,     0, 0, 0, 0, 0, 0, 0, 0,          5'b00000, 0, 0, 0);
    // enqueue under inval is dropped; stray ack/done while idle are ignored
    add(1, 'hD00, 8, 0, 0, 0, 1, 0, 0, 0, 0,          5'b00000, 0, 0, 0);
    add(0, 0, 0,     0, 0, 0, 0, 1, 1, 0, 'h88888,    5'b00000, 0, 0, 0);
    add(0, 0, 0,     0, 0, 0, 0, 0, 0, 0, 0,          5'b00000, 0, 0, 0);

    repeat (3) @(posedge clk);
    #1;
    check("rst_flags", 64'({ptw_req, wr_entry, fault_valid, miss_busy, miss_full}), 64'(0));
    check("rst_state", 64'(dbg_state), 64'(IDLE));
    check("rst_vaddrs", 64'(ptw_req_vaddr | wr_vaddr | fault_vaddr), 64'(0));
    reset = 1'b0;

    for (int i = 0; i < n_vec; i++) begin
      @(posedge clk); #1;
      miss_0 = tbl[i].m0; miss_vaddr_0 = tbl[i].va0; miss_asid_0 = tbl[i].as0;
      miss_1 = tbl[i].m1; miss_vaddr_1 = tbl[i].va1; miss_asid_1 = tbl[i].as1;
      inval = tbl[i].inv; ptw_ack = tbl[i].ack; ptw_done = tbl[i].done;
      ptw_fault = tbl[i].flt; ptw_paddr = tbl[i].pa;
      #1;
      check($sformatf("row%0d_flags", i),
            64'({ptw_req, wr_entry, fault_valid, miss_busy, miss_full}), 64'(tbl[i].flags));
      if (tbl[i].flags[4]) begin
        check($sformatf("row%0d_req_va", i), 64'(ptw_req_vaddr), 64'(tbl[i].eva));
        check($sformatf("row%0d_req_asid", i), 64'(ptw_req_asid), 64'(tbl[i].eas));
      end
      if (tbl[i].flags[3]) begin
        check($sformatf("row%0d_wr_va", i), 64'(wr_vaddr), 64'(tbl[i].eva));
        check($sformatf("row%0d_wr_asid", i), 64'(wr_asid), 64'(tbl[i].eas));
        check($sformatf("row%0d_wr_pa", i), 64'(wr_paddr), 64'(tbl[i].epa));
      end
      if (tbl[i].flags[2]) check($sformatf("row%0d_fault_va", i), 64'(fault_vaddr), 64'(tbl[i].eva));
    end
    drive_zero();

    // queue fills while the PTW stalls on ack; the extra miss is dropped
    walks = 0;
    exp_q.delete();
    @(posedge clk); #1; miss_0 = 1; miss_vaddr_0 = 'hE01; miss_asid_0 = 9;
    @(posedge clk); #1; drive_zero();
    @(posedge clk); #1; check("full_req_stall", 64'(ptw_req), 64'(1));
    miss_0 = 1; miss_vaddr_0 = 'hE02; miss_asid_0 = 9;
    miss_1 = 1; miss_vaddr_1 = 'hE03; miss_asid_1 = 9;
    @(posedge clk); #1; check("full_set", 64'(miss_full), 64'(1));
    drive_zero(); miss_0 = 1; miss_vaddr_0 = 'hE04; miss_asid_0 = 9;
    @(posedge clk); #1; drive_zero();
    check("full_hold", 64'(miss_full), 64'(1));
    check("full_req_held", 64'(ptw_req), 64'(1));
    exp_q.push_back('hE01); exp_q.push_back('hE02); exp_q.push_back('hE03);
    serve(30);
    check("full_walks", 64'(walks), 64'(3));
    check("full_left", 64'(exp_q.size()), 64'(0));
    check("full_idle_busy", 64'(miss_busy), 64'(0));

    // one free slot: port 0 taken, port 1 dropped
    walks = 0;
    exp_q.delete();
    @(posedge clk); #1; miss_0 = 1; miss_vaddr_0 = 'hF01; miss_asid_0 = 9;
    @(posedge clk); #1; drive_zero();
    @(posedge clk); #1; miss_0 = 1; miss_vaddr_0 = 'hF02; miss_asid_0 = 9;
    @(posedge clk); #1; check("slot1_not_full", 64'(miss_full), 64'(0));
    miss_0 = 1; miss_vaddr_0 = 'hF03; miss_asid_0 = 9;
    miss_1 = 1; miss_vaddr_1 = 'hF04; miss_asid_1 = 9;
    @(posedge clk); #1; drive_zero();
    check("slot1_full", 64'(miss_full), 64'(1));
    exp_q.push_back('hF01); exp_q.push_back('hF02); exp_q.push_back('hF03);
    serve(30);
    check("slot1_walks", 64'(walks), 64'(3));
    check("slot1_left", 64'(exp_q.size()), 64'(0));

    // asynchronous reset between edges while a request is pending
    @(posedge clk); #1;
    miss_0 = 1; miss_vaddr_0 = 'h1A1; miss_asid_0 = 2;
    miss_1 = 1; miss_vaddr_1 = 'h1A2; miss_asid_1 = 2;
    @(posedge clk); #1; drive_zero();
    @(posedge clk); #1; check("areset_pre_req", 64'(ptw_req), 64'(1));
    #2 reset = 1'b1;
    #1;
    check("areset_now", 64'({ptw_req, miss_busy, wr_entry}), 64'(0));
    check("areset_state", 64'(dbg_state), 64'(IDLE));
    #3 reset = 1'b0;
    @(posedge clk); #1;
    check("areset_after", 64'({ptw_req, miss_busy, miss_full}), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
